// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: occupancy state encoding
// and bit offsets of the fields packed into the control bundle.
package id_ex_pipe_reg_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int unsigned CTRL_RD_LSB   = 0;
    localparam int unsigned CTRL_RS1_LSB  = 5;
    localparam int unsigned CTRL_RS2_LSB  = 10;
    localparam int unsigned CTRL_ALU_LSB  = 15;
    localparam int unsigned CTRL_JAL_BIT  = 19;
    localparam int unsigned CTRL_JALR_BIT = 20;
    localparam int unsigned CTRL_BR_BIT   = 21;
    localparam int unsigned CTRL_MEM_BIT  = 22;
    localparam int unsigned CTRL_WEN_BIT  = 23;
    localparam int unsigned CTRL_BITS     = 24;

    function automatic logic [CTRL_BITS-1:0] pack_ctrl(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [3:0] alu,
        input logic       jal,
        input logic       jalr,
        input logic       branch,
        input logic       mem,
        input logic       reg_wen
    );
        logic [CTRL_BITS-1:0] c;
        c = '0;
        c[CTRL_RD_LSB  +: 5] = rd;
        c[CTRL_RS1_LSB +: 5] = rs1;
        c[CTRL_RS2_LSB +: 5] = rs2;
        c[CTRL_ALU_LSB +: 4] = alu;
        c[CTRL_JAL_BIT]      = jal;
        c[CTRL_JALR_BIT]     = jalr;
        c[CTRL_BR_BIT]       = branch;
        c[CTRL_MEM_BIT]      = mem;
        c[CTRL_WEN_BIT]      = reg_wen;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_skid_entry.sv
// One buffered ID/EX entry: valid flag, payload and control bundle.
// clear drops the entry and zeroes control but leaves the payload in place.
module id_ex_skid_entry #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with optional two-entry skid buffer, flush and
// a saturating bubble counter for cycles where execute was idle but ready.
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 24,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              pop;
    logic [CNT_W-1:0]  bubble_q;

    assign out_valid  = main_valid;
    assign out_data   = main_data;
    assign out_ctrl   = main_ctrl;
    assign pop        = main_valid && out_ready;
    assign bubble_cnt = bubble_q;

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0]        state;
            logic [1:0]        state_nxt;
            logic              ready_q;
            logic              push;
            logic              main_load;
            logic              main_clear;
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] main_src_data;
            logic [CTRL_W-1:0] main_src_ctrl;

            assign push = in_valid && ready_q && !flush;

            always_comb begin
                state_nxt  = state;
                main_load  = 1'b0;
                main_clear = 1'b0;
                skid_load  = 1'b0;
                skid_clear = 1'b0;
                if (flush) begin
                    state_nxt  = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (push) begin
                                state_nxt = ST_ONE;
                                main_load = 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (push && pop) begin
                                main_load = 1'b1;
                            end else if (push) begin
                                state_nxt = ST_TWO;
                                skid_load = 1'b1;
                            end else if (pop) begin
                                state_nxt  = ST_EMPTY;
                                main_clear = 1'b1;
                            end
                        end
                        ST_TWO: begin
                            if (pop) begin
                                state_nxt  = ST_ONE;
                                main_load  = 1'b1;
                                skid_clear = 1'b1;
                            end
                        end
                        default: begin
                            state_nxt  = ST_EMPTY;
                            main_clear = 1'b1;
                            skid_clear = 1'b1;
                        end
                    endcase
                end
            end

            // A valid skid entry is always older than anything on the input.
            assign main_src_data = skid_valid ? skid_data : in_data;
            assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;

            // in_ready is looked up from the next state so it never sees out_ready combinationally.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state   <= state_nxt;
                    ready_q <= (state_nxt != ST_TWO);
                end
            end

            id_ex_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (main_load),
                .clear     (main_clear),
                .load_data (main_src_data),
                .load_ctrl (main_src_ctrl),
                .valid     (main_valid),
                .data      (main_data),
                .ctrl      (main_ctrl)
            );

            id_ex_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (skid_load),
                .clear     (skid_clear),
                .load_data (in_data),
                .load_ctrl (in_ctrl),
                .valid     (skid_valid),
                .data      (skid_data),
                .ctrl      (skid_ctrl)
            );

            assign in_ready  = ready_q;
            assign occupancy = (state == ST_TWO) ? 2'd2 :
                               (state == ST_ONE) ? 2'd1 : 2'd0;
        end else begin : g_single
            logic push;

            assign in_ready = !main_valid || out_ready;
            assign push     = in_valid && in_ready && !flush;

            id_ex_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (push),
                .clear     (flush || (pop && !push)),
                .load_data (in_data),
                .load_ctrl (in_ctrl),
                .valid     (main_valid),
                .data      (main_data),
                .ctrl      (main_ctrl)
            );

            assign occupancy = {1'b0, main_valid};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_q <= '0;
        end else if (!main_valid && out_ready && (bubble_q != '1)) begin
            bubble_q <= bubble_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a skid instance (CNT_W=4) and a single-register
// instance, both tracked by a bounded-FIFO reference model every cycle.
module tb_id_ex_pipe_reg;

    localparam int unsigned DW = 128;
    localparam int unsigned CW = 24;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } item_t;

    typedef struct {
        logic          rst_n;
        logic          iv;
        logic [CW-1:0] ic;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic [CW-1:0] e_oc;
        logic [1:0]    e_occ;
        logic          e_ir;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iv   [2];
    logic          ordy [2];
    logic          fl   [2];
    logic [DW-1:0] id   [2];
    logic [CW-1:0] ic   [2];
    logic          ir   [2];
    logic          ov   [2];
    logic [DW-1:0] od   [2];
    logic [CW-1:0] oc   [2];
    logic [1:0]    occ  [2];
    logic [3:0]    bub_a;
    logic [15:0]   bub_b;

    item_t       mq   [2][2];
    int unsigned mcnt [2];
    int unsigned mbub [2];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (iv[0]),
        .in_ready   (ir[0]),
        .in_data    (id[0]),
        .in_ctrl    (ic[0]),
        .out_valid  (ov[0]),
        .out_ready  (ordy[0]),
        .out_data   (od[0]),
        .out_ctrl   (oc[0]),
        .flush      (fl[0]),
        .occupancy  (occ[0]),
        .bubble_cnt (bub_a)
    );

    id_ex_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (iv[1]),
        .in_ready   (ir[1]),
        .in_data    (id[1]),
        .in_ctrl    (ic[1]),
        .out_valid  (ov[1]),
        .out_ready  (ordy[1]),
        .out_data   (od[1]),
        .out_ctrl   (oc[1]),
        .flush      (fl[1]),
        .occupancy  (occ[1]),
        .bubble_cnt (bub_b)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned bub(input int k);
        return (k == 0) ? int'(bub_a) : int'(bub_b);
    endfunction

    function automatic int unsigned bub_max(input int k);
        return (k == 0) ? 15 : 65535;
    endfunction

    // Skid stage accepts while fewer than two entries are held; the single
    // register accepts when empty or when its entry leaves this cycle.
    function automatic logic m_ir(input int k);
        if (k == 0) return (mcnt[0] < 2);
        return (mcnt[1] == 0) || ordy[1];
    endfunction

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid[%0d]", k), DW'(ov[k]), DW'(mcnt[k] != 0));
            chk($sformatf("out_ctrl[%0d]", k), DW'(oc[k]),
                DW'((mcnt[k] != 0) ? mq[k][0].ctrl : {CW{1'b0}}));
            if (mcnt[k] != 0)
                chk($sformatf("out_data[%0d]", k), od[k], mq[k][0].data);
            chk($sformatf("in_ready[%0d]", k), DW'(ir[k]), DW'(m_ir(k)));
            chk($sformatf("occupancy[%0d]", k), DW'(occ[k]), DW'(mcnt[k]));
            chk($sformatf("bubble_cnt[%0d]", k), DW'(bub(k)), DW'(mbub[k]));
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic pop;
            logic push;
            if (!rst_n) begin
                mcnt[k] = 0;
                mbub[k] = 0;
            end else begin
                if (mcnt[k] == 0 && ordy[k] && mbub[k] < bub_max(k)) mbub[k]++;
                if (fl[k]) begin
                    mcnt[k] = 0;
                end else begin
                    pop  = (mcnt[k] != 0) && ordy[k];
                    push = iv[k] && m_ir(k);
                    if (pop) begin
                        mq[k][0] = mq[k][1];
                        mcnt[k]--;
                    end
                    if (push) begin
                        mq[k][mcnt[k]] = {id[k], ic[k]};
                        mcnt[k]++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        check_model();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
        fl[k]   = 1'b0;
        ic[k]   = '0;
        id[k]   = '0;
    endtask

    initial begin
        vec_t          tbl [17];
        logic [DW-1:0] pat;
        int unsigned   sent;
        int unsigned   got;
        int unsigned   cyc;

        pat = {16{8'hA5}};
        //          rst iv  ic          ordy fl   ov  oc          occ   ir
        tbl[0]  = '{1'b1, 1'b1, 24'h001234, 1'b1, 1'b0, 1'b1, 24'h001234, 2'd1, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h000000, 2'd0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 24'h000011, 1'b0, 1'b0, 1'b1, 24'h000011, 2'd1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 24'h000022, 1'b0, 1'b0, 1'b1, 24'h000011, 2'd2, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000011, 2'd2, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 24'h000022, 2'd1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h000000, 2'd0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 24'h000044, 1'b0, 1'b0, 1'b1, 24'h000044, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 24'h000055, 1'b0, 1'b0, 1'b1, 24'h000044, 2'd2, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 24'h000033, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h000000, 2'd0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 24'h000066, 1'b0, 1'b0, 1'b1, 24'h000066, 2'd1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 24'h000077, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 24'h000088, 1'b0, 1'b0, 1'b1, 24'h000088, 2'd1, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 24'h000099, 1'b0, 1'b0, 1'b1, 24'h000088, 2'd2, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 24'h0000AA, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h000000, 2'd0, 1'b1};

        rst_n = 1'b0;
        idle(0);
        idle(1);
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mbub[k] = 0;
        end
        @(negedge clk);
        #1;
        chk("rst_out_valid", DW'(ov[0]), DW'(1'b0));
        chk("rst_occupancy", DW'(occ[0]), DW'(2'd0));
        chk("rst_in_ready", DW'(ir[0]), DW'(1'b1));
        chk("rst_bubble", DW'(bub_a), DW'(4'd0));
        chk("rst_data", od[0], {DW{1'b0}});
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            rst_n   = tbl[i].rst_n;
            iv[0]   = tbl[i].iv;
            ic[0]   = tbl[i].ic;
            ordy[0] = tbl[i].ordy;
            fl[0]   = tbl[i].fl;
            id[0]   = pat ^ DW'(i);
            tick();
            #1;
            chk($sformatf("tbl%0d_out_valid", i), DW'(ov[0]), DW'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_ctrl", i), DW'(oc[0]), DW'(tbl[i].e_oc));
            chk($sformatf("tbl%0d_occupancy", i), DW'(occ[0]), DW'(tbl[i].e_occ));
            chk($sformatf("tbl%0d_in_ready", i), DW'(ir[0]), DW'(tbl[i].e_ir));
        end
        rst_n = 1'b1;

        // Bubble counter saturation on the 4-bit instance, then reset clears it.
        idle(0);
        for (int c = 0; c < 20; c++) tick();
        #1;
        chk("bubble_sat", DW'(bub_a), DW'(4'd15));
        tick();
        #1;
        chk("bubble_hold", DW'(bub_a), DW'(4'd15));
        rst_n = 1'b0;
        tick();
        #1;
        chk("bubble_rst", DW'(bub_a), DW'(4'd0));
        rst_n = 1'b1;

        // Single-register mode: stall backpressure is combinational, and
        // pop plus push on one edge keeps one entry.
        iv[1]   = 1'b1;
        ic[1]   = 24'h000005;
        ordy[1] = 1'b0;
        tick();
        #1;
        chk("reg_out_valid", DW'(ov[1]), DW'(1'b1));
        chk("reg_in_ready_stall", DW'(ir[1]), DW'(1'b0));
        ordy[1] = 1'b1;
        ic[1]   = 24'h000006;
        #1;
        chk("reg_in_ready_go", DW'(ir[1]), DW'(1'b1));
        tick();
        #1;
        chk("reg_occupancy", DW'(occ[1]), DW'(2'd1));
        chk("reg_out_ctrl", DW'(oc[1]), DW'(24'h000006));
        idle(1);

        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 1) == 1);
                fl[k]   = ($urandom_range(0, 31) == 0);
                ic[k]   = CW'($urandom);
                id[k]   = {$urandom, $urandom, $urandom, $urandom};
            end
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end

        // Ordered stream of ctrl 1..100 through the skid instance.
        idle(0);
        idle(1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 100 && cyc < 2000) begin
            iv[0]   = (sent < 100);
            ic[0]   = CW'(sent + 1);
            id[0]   = {4{32'(sent + 1)}};
            ordy[0] = ($urandom_range(0, 1) == 1);
            fl[0]   = 1'b0;
            #1;
            if (mcnt[0] != 0 && ordy[0]) begin
                got++;
                chk($sformatf("stream_out%0d", got), DW'(oc[0]), DW'(got));
            end
            if (iv[0] && m_ir(0)) sent++;
            tick();
            cyc++;
        end
        chk("stream_count", DW'(got), DW'(100));
        idle(0);
        tick();
        #1;
        chk("stream_drained", DW'(ov[0]), DW'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of payload (register data, imm, pc) not cleared on flush.
REQ-002 SHALL have parameter CTRL_W, default 24, width of control bundle (rd, rs1, rs2, alu ctrl, jal/jalr/branch/mem/reg-wen bits) cleared on flush.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry skid buffer with registered in_ready, 0 = single register.
REQ-004 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-005 SHALL have ports: clk input 1 clock; rst_n input 1 reset, synchronous, active-low.
REQ-006 SHALL have ports: in_valid input 1 decode result valid; in_ready output 1 stage can accept; in_data input DATA_W; in_ctrl input CTRL_W.
REQ-007 SHALL have ports: out_valid output 1; out_ready input 1 execute accepts; out_data output DATA_W; out_ctrl output CTRL_W.
REQ-008 SHALL have ports: flush input 1 kill all held entries; occupancy output 2 entries held (0..2); bubble_cnt output CNT_W.

Function
REQ-009 Transfer in SHALL occur on a clk edge with in_valid && in_ready && !flush; transfer out with out_valid && out_ready.
REQ-010 SKID=1: states EMPTY, ONE, TWO; occupancy SHALL equal 0/1/2 respectively.
REQ-011 SKID=1 transitions: EMPTY+push->ONE; ONE+push+pop->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; TWO+pop->ONE (skid entry moves to main); no other changes.
REQ-012 SKID=1: in_ready SHALL be a register output, 1 in EMPTY/ONE, 0 in TWO; push while TWO cannot occur.
REQ-013 SKID=0: in_ready SHALL be !out_valid || out_ready (combinational); occupancy SHALL be 0 or 1.
REQ-014 Entries SHALL leave in arrival order; latency in->out SHALL be exactly 1 cycle when the stage is EMPTY.
REQ-015 out_data/out_ctrl SHALL be driven from the main entry only; out_ctrl SHALL be all-zero whenever out_valid=0.
REQ-016 While out_valid=1 and out_ready=0, out_data and out_ctrl SHALL hold stable.
REQ-017 flush SHALL on the same edge clear all valids, set state EMPTY, zero stored ctrl, and drop any concurrent input; stored data need not be cleared.
REQ-018 flush SHALL take priority over push and pop; in_ready SHALL be 1 in the cycle after flush.
REQ-019 bubble_cnt SHALL increment each cycle out_valid=0 && out_ready=1, saturating at 2^CNT_W-1, not affected by flush.

Reset
REQ-020 On rst_n=0 at a clk edge: state EMPTY, out_valid 0, occupancy 0, all stored data and ctrl 0, bubble_cnt 0, in_ready 1 (SKID=1).
REQ-021 Reset SHALL override flush, push and pop in the same cycle; reset mid-operation discards all entries.

Structure
REQ-022 Shared package SHALL hold the state encoding (EMPTY/ONE/TWO) and ctrl-field offset constants used to pack in_ctrl.
REQ-023 One sub-module SHALL be natural: id_ex_skid_entry (valid+data+ctrl register with load/clear), instantiated twice for SKID=1, once for SKID=0.
REQ-024 No combinational path from out_ready to in_ready SHALL exist when SKID=1.

Verification
REQ-025 Reset then in_valid=1, in_ctrl=0x00_1234, in_data=0xA5.., out_ready=1 -> next cycle out_valid=1, out_ctrl=0x001234, occupancy=1.
REQ-026 SKID=1, out_ready=0, push ctrl 0x11 then 0x22 -> occupancy 2, in_ready=0; raise out_ready -> outputs 0x11 then 0x22 on consecutive cycles, in_ready=1 one cycle after first pop.
REQ-027 Stage in TWO, flush=1 with in_valid=1 ctrl 0x33 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0x33 never appears.
REQ-028 Streaming 100 entries ctrl 1..100 with random out_ready (50%) -> output sequence 1..100 in order, no loss, no duplicate, out stable while stalled.
REQ-029 CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt=15 and holds; rst_n=0 -> bubble_cnt=0.
REQ-030 SKID=0, out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> pop and push same edge, occupancy stays 1.
